// File: rtl/note_sequencer.sv
// note_sequencer: plays note/octave/duration steps from a small memory and
// produces a square-wave tone whose half-period comes from the freq_div lookup.
module note_sequencer #(
  parameter int DEPTH = 16,
  parameter int TICK_DIV = 120000,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W:0]   seq_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [14:0]       wr_data,
  output logic [3:0]        note,
  output logic [2:0]        octave,
  input  logic [18:0]       divider,
  output logic              tone,
  output logic              busy,
  output logic [ADDR_W-1:0] step,
  output logic              done
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, PLAY = 2'd2;
  logic [1:0] state;
  logic [14:0] mem [DEPTH];
  logic [7:0] dur;
  logic [ADDR_W:0] len;
  logic [18:0] div_q, tcnt;
  logic [PW-1:0] pre;
  logic play_end, last, sounding, go, pre_wrap;
  logic [ADDR_W-1:0] nxt;
  logic [14:0] nxt_word;
  assign busy = state != IDLE;
  assign pre_wrap = pre == PRE_MAX;
  assign play_end = dur == 8'd0 || (dur == 8'd1 && pre_wrap);
  assign last = {1'b0, step} == len - (ADDR_W + 1)'(1);
  assign nxt = last ? '0 : step + ADDR_W'(1);
  assign nxt_word = mem[nxt];
  assign sounding = note < 4'd13 && div_q != 19'd0;
  assign go = start && !stop && seq_len != '0;
  always_ff @(posedge hwclk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state <= IDLE;
      note <= '0;
      octave <= '0;
      dur <= '0;
      step <= '0;
      len <= '0;
      div_q <= '0;
      tcnt <= '0;
      pre <= '0;
      tone <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        tone <= 1'b0;
      end else if (state == IDLE) begin
        if (go) begin
          {dur, octave, note} <= mem[0];
          step <= '0;
          len <= seq_len > DEPTH_L ? DEPTH_L : seq_len;
          state <= FETCH;
        end
      end else if (state == FETCH) begin
        div_q <= divider;
        tcnt <= '0;
        pre <= '0;
        tone <= 1'b0;
        state <= PLAY;
      end else begin
        pre <= pre_wrap ? '0 : pre + PW'(1);
        if (pre_wrap && dur != 8'd0) dur <= dur - 8'd1;
        if (sounding) begin
          tcnt <= tcnt == div_q - 19'd1 ? 19'd0 : tcnt + 19'd1;
          if (tcnt == div_q - 19'd1) tone <= ~tone;
        end
        // step boundary: later assignments override the counter updates above
        if (play_end) begin
          tone <= 1'b0;
          if (last && !loop_en) begin
            state <= IDLE;
            done <= 1'b1;
          end else begin
            {dur, octave, note} <= nxt_word;
            step <= nxt;
            state <= FETCH;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: vector table plus scoreboard checks for note_sequencer,
// with a stubbed divider on one instance and a freq_div model on a second.
module tb_note_sequencer;
  localparam int AW = 4;
  localparam int TD = 10;
  typedef struct { int dur; int oct; int note; int div; } vec_t;
  typedef struct { int busy_cyc; int high; int note; int oct; } exp_t;
  logic hwclk = 0, reset = 1, start = 0, stop = 0, loop_en = 0, wr_en = 0;
  logic start2 = 0, stop2 = 0;
  logic [AW:0] seq_len = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [14:0] wr_data = '0;
  logic [18:0] stub_div = '0, divider2;
  logic [3:0] note, note2;
  logic [2:0] octave, octave2;
  logic tone, busy, done, tone2, busy2, done2;
  logic [AW-1:0] step, step2;
  int tests = 0, fails = 0;
  exp_t sb[$];
  vec_t vecs[6];

  note_sequencer #(.DEPTH(16), .TICK_DIV(TD)) u_dut (
    .hwclk(hwclk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .note(note), .octave(octave), .divider(stub_div), .tone(tone), .busy(busy),
    .step(step), .done(done));

  note_sequencer #(.DEPTH(16), .TICK_DIV(200)) u_real (
    .hwclk(hwclk), .reset(reset), .start(start2), .stop(stop2), .loop_en(loop_en),
    .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .note(note2), .octave(octave2), .divider(divider2), .tone(tone2), .busy(busy2),
    .step(step2), .done(done2));

  always #5 hwclk = ~hwclk;

  // freq_div model: octave-0 half-periods at 12 MHz, halved per octave
  function automatic logic [18:0] real_div(logic [3:0] n, logic [2:0] o);
    logic [18:0] base;
    base = n >= 4'd13 ? 19'd0 : n == 4'd9 ? 19'd181808 : 19'd200000 - 19'(n) * 19'd1500;
    return base >> o;
  endfunction
  always_comb divider2 = real_div(note2, octave2);

  function automatic int exp_high(int p, int d, int n);
    int h = 0;
    if (n >= 13 || d == 0) return 0;
    for (int j = 0; j < p; j++) h += (j / d) % 2;
    return h;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(int a, int d, int o, int n);
    wr_addr = AW'(a);
    wr_data = {8'(d), 3'(o), 4'(n)};
    wr_en = 1;
    @(negedge hwclk);
    wr_en = 0;
  endtask

  task automatic pulse_start(int len);
    seq_len = (AW + 1)'(len);
    start = 1;
    @(negedge hwclk);
    start = 0;
  endtask

  task automatic run_one(int i, vec_t v);
    exp_t e;
    int p, bc = 0, hc = 0, dc = 0, n0, o0;
    stub_div = 19'(v.div);
    wr(0, v.dur, v.oct, v.note);
    p = v.dur == 0 ? 1 : v.dur * TD;
    e.busy_cyc = p + 1;
    e.high = exp_high(p, v.div, v.note);
    e.note = v.note;
    e.oct = v.oct;
    sb.push_back(e);
    loop_en = 0;
    pulse_start(1);
    n0 = note;
    o0 = octave;
    for (int c = 0; c < 5000 && busy; c++) begin
      bc++;
      hc += int'(tone);
      dc += int'(done);
      @(negedge hwclk);
    end
    for (int c = 0; c < 3; c++) begin
      dc += int'(done);
      hc += int'(tone);
      @(negedge hwclk);
    end
    e = sb.pop_front();
    check($sformatf("v%0d_busy_cycles", i), bc, e.busy_cyc);
    check($sformatf("v%0d_tone_high", i), hc, e.high);
    check($sformatf("v%0d_done_pulses", i), dc, 1);
    check($sformatf("v%0d_note_oct_loaded", i), n0 * 8 + o0, e.note * 8 + e.oct);
    check($sformatf("v%0d_note_held", i), int'(note), e.note);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, bc, dc, t_rise, t_fall, t_rise2;
    vecs[0] = '{2, 4, 9, 3};
    vecs[1] = '{1, 2, 13, 3};
    vecs[2] = '{0, 1, 2, 3};
    vecs[3] = '{1, 3, 5, 0};
    vecs[4] = '{3, 0, 1, 4};
    vecs[5] = '{1, 5, 12, 1};
    repeat (2) @(negedge hwclk);
    check("reset_outputs", int'({note, octave, tone, busy, step, done}), 0);
    check("reset_busy2", int'(busy2), 0);
    reset = 0;
    for (int i = 0; i < 6; i++) run_one(i, vecs[i]);

    // looping three-step sequence, then stop
    stub_div = 19'd2;
    for (int i = 0; i < 3; i++) wr(i, 1, 2, i + 1);
    loop_en = 1;
    pulse_start(3);
    bad = 0;
    dc = 0;
    for (int c = 0; c <= 80; c++) begin
      if (int'(step) != (c / 11) % 3 || int'(note) != (c / 11) % 3 + 1 || !busy) bad++;
      dc += int'(done);
      if (c < 80) @(negedge hwclk);
    end
    check("loop_step_sequence_errors", bad, 0);
    check("loop_no_done", dc, 0);
    check("loop_tone_before_stop", int'(tone), 1);
    stop = 1;
    @(negedge hwclk);
    stop = 0;
    check("stop_outputs", int'({busy, tone, done}), 0);
    loop_en = 0;
    repeat (2) @(negedge hwclk);

    // zero-duration middle step
    wr(0, 1, 1, 1);
    wr(1, 0, 1, 2);
    wr(2, 1, 1, 3);
    pulse_start(3);
    bad = 0;
    bc = 0;
    dc = 0;
    for (int c = 0; c < 100 && busy; c++) begin
      if (int'(step) != (c < 11 ? 0 : c < 13 ? 1 : 2)) bad++;
      bc++;
      dc += int'(done);
      @(negedge hwclk);
    end
    dc += int'(done);
    check("dur0_step_errors", bad, 0);
    check("dur0_busy_cycles", bc, 24);
    check("dur0_done", dc, 1);

    // ignored starts
    pulse_start(0);
    @(negedge hwclk);
    check("len0_start_ignored", int'(busy), 0);
    seq_len = 5'd1;
    start = 1;
    stop = 1;
    @(negedge hwclk);
    start = 0;
    stop = 0;
    @(negedge hwclk);
    check("start_stop_ignored", int'(busy), 0);

    // seq_len above DEPTH plays all 16 steps; a mid-play start changes nothing
    for (int i = 0; i < 16; i++) wr(i, 0, 3, i % 13);
    pulse_start(20);
    bc = 0;
    dc = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      start = c == 10;
      bc++;
      dc += int'(done);
      @(negedge hwclk);
    end
    start = 0;
    dc += int'(done);
    check("len20_busy_cycles", bc, 32);
    check("len20_done", dc, 1);
    check("len20_final_step", int'(step), 15);
    repeat (2) @(negedge hwclk);

    // reset during PLAY
    stub_div = 19'd3;
    wr(0, 2, 4, 9);
    pulse_start(1);
    repeat (5) @(negedge hwclk);
    check("pre_reset_tone", int'(tone), 1);
    reset = 1;
    @(negedge hwclk);
    check("mid_play_reset_outputs", int'({note, octave, tone, busy, step, done}), 0);
    reset = 0;
    @(negedge hwclk);

    // second instance with the freq_div model: measure the real tone period
    wr(0, 255, 4, 9);
    seq_len = 5'd1;
    start2 = 1;
    @(negedge hwclk);
    start2 = 0;
    t_rise = -1;
    t_fall = -1;
    t_rise2 = -1;
    for (int c = 0; c < 40000 && t_rise2 < 0; c++) begin
      @(negedge hwclk);
      if (tone2 && t_rise < 0) t_rise = c;
      else if (!tone2 && t_rise >= 0 && t_fall < 0) t_fall = c;
      else if (tone2 && t_fall >= 0) t_rise2 = c;
    end
    check("real_tone_high_cycles", t_fall - t_rise, 11363);
    check("real_tone_period", t_rise2 - t_rise, 22726);
    stop2 = 1;
    @(negedge hwclk);
    stop2 = 0;
    check("real_stop_outputs", int'({busy2, tone2, done2}), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
